// File: rtl/dog_extrema_finder.sv
// Scans a finished DoG image in BRAM and emits strict 3x3 local extrema as (x, y) keypoints.
// Optional build macro: CONTRAST_THRESH_EN (require |centre| >= THRESHOLD for a keypoint).
module dog_extrema_finder #(
    parameter int unsigned DIMENSION    = 64,
    parameter int unsigned BRAM_LATENCY = 2,
    parameter int unsigned THRESHOLD    = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_in,
    input  logic                                    bram_ready,
    output logic [$clog2(DIMENSION*DIMENSION)-1:0]  address,
    input  logic [8:0]                              data_in,
    output logic                                    keypoint_valid,
    input  logic                                    keypoint_ready,
    output logic [$clog2(DIMENSION)-1:0]            keypoint_x,
    output logic [$clog2(DIMENSION)-1:0]            keypoint_y,
    output logic                                    keypoint_is_max,
    output logic [15:0]                             keypoint_count,
    output logic                                    busy,
    output logic                                    done
);

    localparam int unsigned XW = $clog2(DIMENSION);
    localparam int unsigned AW = $clog2(DIMENSION * DIMENSION);
    localparam int unsigned CW = $clog2(9 + BRAM_LATENCY);
`ifdef CONTRAST_THRESH_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_COMPARE,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [XW-1:0]          r_x;
    logic [XW-1:0]          r_y;
    logic [CW-1:0]          r_cnt;
    logic [AW-1:0]          r_addr;
    logic signed [8:0]      r_samp [9];
    logic                   r_valid;
    logic [XW-1:0]          r_kx;
    logic [XW-1:0]          r_ky;
    logic                   r_kmax;
    logic [15:0]            r_count;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_gt_all;
    logic                   w_lt_all;
    logic [8:0]             w_mag;
    logic                   w_contrast_ok;
    logic                   w_hit;
    logic                   w_last;
    logic [XW-1:0]          w_adv_x;
    logic [XW-1:0]          w_adv_y;

    // Address of neighbour idx (row-major 3x3, idx 4 = centre) around pixel (px, py)
    function automatic logic [AW-1:0] f_addr(input logic [XW-1:0] px,
                                             input logic [XW-1:0] py,
                                             input logic [3:0]    idx);
        logic [AW-1:0] row;
        logic [AW-1:0] col;
        row = AW'(py) + AW'(idx / 4'd3) - AW'(1);
        col = AW'(px) + AW'(idx % 4'd3) - AW'(1);
        return AW'(row * AW'(DIMENSION)) + col;
    endfunction

    always_comb begin
        w_gt_all = 1'b1;
        w_lt_all = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                if (!(r_samp[4] > r_samp[i])) w_gt_all = 1'b0;
                if (!(r_samp[4] < r_samp[i])) w_lt_all = 1'b0;
            end
        end
    end

    // -256 maps to 256, which still fits the 9-bit unsigned magnitude
    assign w_mag         = r_samp[4][8] ? 9'(-r_samp[4]) : 9'(r_samp[4]);
    assign w_contrast_ok = !THRESH_EN || (w_mag >= 9'(THRESHOLD));
    assign w_hit         = (w_gt_all || w_lt_all) && w_contrast_ok;
    assign w_last        = (r_x == XW'(DIMENSION - 2)) && (r_y == XW'(DIMENSION - 2));
    assign w_adv_x       = (r_x == XW'(DIMENSION - 2)) ? XW'(1) : r_x + XW'(1);
    assign w_adv_y       = (r_x == XW'(DIMENSION - 2)) ? r_y + XW'(1) : r_y;

    always_ff @(posedge clk) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bram_ready) w_next = S_FETCH;
            S_FETCH:   if (r_cnt == CW'(8 + BRAM_LATENCY)) w_next = S_COMPARE;
            S_COMPARE: begin
                if (w_hit)       w_next = S_EMIT;
                else if (w_last) w_next = S_FINISH;
                else             w_next = S_FETCH;
            end
            S_EMIT:    if (r_valid && keypoint_ready) w_next = w_last ? S_FINISH : S_FETCH;
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_x     <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_kx    <= '0;
            r_ky    <= '0;
            r_kmax  <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 9; i++) r_samp[i] <= '0;
        end else begin
            r_busy <= (w_next == S_FETCH) || (w_next == S_COMPARE) || (w_next == S_EMIT);
            r_done <= (w_next == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (bram_ready) begin
                        r_x     <= XW'(1);
                        r_y     <= XW'(1);
                        r_cnt   <= '0;
                        r_count <= '0;
                        r_addr  <= f_addr(XW'(1), XW'(1), 4'd0);
                    end
                end
                S_FETCH: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt < CW'(8))
                        r_addr <= f_addr(r_x, r_y, 4'(r_cnt) + 4'd1);
                    if (r_cnt >= CW'(BRAM_LATENCY))
                        r_samp[r_cnt - CW'(BRAM_LATENCY)] <= data_in;
                end
                S_COMPARE: begin
                    r_cnt <= '0;
                    if (w_hit) begin
                        r_kx    <= r_x;
                        r_ky    <= r_y;
                        r_kmax  <= w_gt_all;
                        r_valid <= 1'b1;
                    end else if (!w_last) begin
                        r_x    <= w_adv_x;
                        r_y    <= w_adv_y;
                        r_addr <= f_addr(w_adv_x, w_adv_y, 4'd0);
                    end
                end
                S_EMIT: begin
                    if (r_valid && keypoint_ready) begin
                        r_valid <= 1'b0;
                        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                        if (!w_last) begin
                            r_x    <= w_adv_x;
                            r_y    <= w_adv_y;
                            r_addr <= f_addr(w_adv_x, w_adv_y, 4'd0);
                        end
                    end
                end
                S_FINISH: r_addr <= '0;
                default:  r_addr <= '0;
            endcase
        end
    end

    assign address         = r_addr;
    assign keypoint_valid  = r_valid;
    assign keypoint_x      = r_kx;
    assign keypoint_y      = r_ky;
    assign keypoint_is_max = r_kmax;
    assign keypoint_count  = r_count;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_dog_extrema_finder.sv
// Scoreboard bench for dog_extrema_finder on a 16x16 image with a 2-cycle BRAM model.
module tb_dog_extrema_finder;

    localparam int unsigned DIM  = 16;
    localparam int unsigned XW   = $clog2(DIM);
    localparam int unsigned AW   = $clog2(DIM * DIM);
    localparam int          BASE = (DIM - 2) * (DIM - 2) * 12;

    logic           clk = 1'b0;
    logic           rst_in = 1'b1;
    logic           bram_ready = 1'b0;
    logic [AW-1:0]  address;
    logic [8:0]     data_in;
    logic           keypoint_valid;
    logic           keypoint_ready = 1'b1;
    logic [XW-1:0]  keypoint_x;
    logic [XW-1:0]  keypoint_y;
    logic           keypoint_is_max;
    logic [15:0]    keypoint_count;
    logic           busy;
    logic           done;

    dog_extrema_finder #(.DIMENSION(DIM), .BRAM_LATENCY(2), .THRESHOLD(4)) dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .bram_ready      (bram_ready),
        .address         (address),
        .data_in         (data_in),
        .keypoint_valid  (keypoint_valid),
        .keypoint_ready  (keypoint_ready),
        .keypoint_x      (keypoint_x),
        .keypoint_y      (keypoint_y),
        .keypoint_is_max (keypoint_is_max),
        .keypoint_count  (keypoint_count),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Registered-output BRAM, two cycles address-to-data
    logic [8:0] mem [DIM*DIM];
    logic [8:0] p1;
    always @(posedge clk) begin
        p1      <= mem[address];
        data_in <= p1;
    end

    typedef struct {
        int x;
        int y;
        int is_max;
    } kp_t;

    kp_t exp_q[$];
    kp_t mon_e;
    int  n_vec = 0;
    int  n_err = 0;
    int  busy_cycles = 0;
    int  done_cnt = 0;
    int  stall_cycles = 0;
    bit  prev_hold = 1'b0;
    int  prev_x, prev_y, prev_m;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < DIM * DIM; i++) mem[i] = '0;
    endtask

    task automatic put(input int x, input int y, input int v);
        mem[y * DIM + x] = 9'(v);
    endtask

    task automatic expect_kp(input int x, input int y, input int m);
        kp_t e;
        e.x = x; e.y = y; e.is_max = m;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, int'(keypoint_valid), 0);
        check({tag, "_x"}, int'(keypoint_x), 0);
        check({tag, "_y"}, int'(keypoint_y), 0);
        check({tag, "_is_max"}, int'(keypoint_is_max), 0);
        check({tag, "_count"}, int'(keypoint_count), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_address"}, int'(address), 0);
    endtask

    // Monitor: scoreboard pops on each accepted keypoint; held keypoints must not change
    always @(negedge clk) begin
        if (rst_in) begin
            prev_hold = 1'b0;
        end else begin
            if (busy) busy_cycles++;
            if (done) done_cnt++;
            if (keypoint_valid && prev_hold) begin
                check("hold_x", int'(keypoint_x), prev_x);
                check("hold_y", int'(keypoint_y), prev_y);
                check("hold_is_max", int'(keypoint_is_max), prev_m);
            end
            if (keypoint_valid && !keypoint_ready) stall_cycles++;
            if (keypoint_valid && keypoint_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_keypoint: got (%0d,%0d,max=%0d), expected none",
                             keypoint_x, keypoint_y, keypoint_is_max);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("kp_x", int'(keypoint_x), mon_e.x);
                    check("kp_y", int'(keypoint_y), mon_e.y);
                    check("kp_is_max", int'(keypoint_is_max), mon_e.is_max);
                end
            end
            prev_hold = keypoint_valid && !keypoint_ready;
            prev_x    = int'(keypoint_x);
            prev_y    = int'(keypoint_y);
            prev_m    = int'(keypoint_is_max);
        end
    end

    task automatic start_pulse();
        @(negedge clk) bram_ready = 1'b1;
        @(negedge clk) bram_ready = 1'b0;
    endtask

    task automatic run_scan(input string tag, input int exp_kp, input int exp_busy,
                            input int exp_stall, input bit poke);
        bit timed_out;
        busy_cycles  = 0;
        done_cnt     = 0;
        stall_cycles = 0;
        start_pulse();
        timed_out = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            bram_ready = poke && (i == 100);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        bram_ready = 1'b0;
        check({tag, "_timeout"}, int'(timed_out), 0);
        repeat (3) @(negedge clk);
        check({tag, "_busy_cycles"}, busy_cycles, exp_busy);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_count"}, int'(keypoint_count), exp_kp);
        check({tag, "_missing_kp"}, exp_q.size(), 0);
        check({tag, "_stall"}, stall_cycles, exp_stall);
        check({tag, "_idle_addr"}, int'(address), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
        exp_q.delete();
    endtask

    task automatic wait_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (keypoint_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_valid_seen"}, int'(seen), 1);
    endtask

    initial begin
        clear_img();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_in = 1'b0;
        @(negedge clk);
        check_zero("post_reset");

        // All-zero image, with a stray start pulse mid-scan
        run_scan("zero", 0, BASE, 0, 1'b1);

        clear_img();
        put(10, 12, 100);
        expect_kp(10, 12, 1);
        run_scan("max", 1, BASE + 1, 0, 1'b0);

        clear_img();
        put(13, 7, -50);
        put(0, 5, 100);
        expect_kp(13, 7, 0);
        run_scan("min_border", 1, BASE + 1, 0, 1'b0);

        clear_img();
        put(12, 12, 100);
        put(13, 12, 100);
        run_scan("plateau", 0, BASE, 0, 1'b0);

        // Consumer stalls for 20 cycles
        clear_img();
        put(5, 5, 100);
        expect_kp(5, 5, 1);
        keypoint_ready = 1'b0;
        fork
            run_scan("backpressure", 1, BASE + 21, 20, 1'b0);
            begin
                wait_valid("backpressure");
                repeat (20) @(posedge clk);
                #1 keypoint_ready = 1'b1;
            end
        join
        keypoint_ready = 1'b1;

        clear_img();
        put(8, 8, 3);
`ifdef CONTRAST_THRESH_EN
        run_scan("weak", 0, BASE, 0, 1'b0);
`else
        expect_kp(8, 8, 1);
        run_scan("weak", 1, BASE + 1, 0, 1'b0);
`endif

        // Corner interior pixels, -256 minimum, adjacent unequal pair
        clear_img();
        put(1, 1, 100);
        put(14, 1, 5);
        put(7, 9, 50);
        put(8, 9, 20);
        put(14, 14, -256);
        expect_kp(1, 1, 1);
        expect_kp(14, 1, 1);
        expect_kp(7, 9, 1);
        expect_kp(14, 14, 0);
        run_scan("edges", 4, BASE + 4, 0, 1'b0);

        // Reset while a keypoint is pending, then rescan
        clear_img();
        put(3, 1, 100);
        keypoint_ready = 1'b0;
        start_pulse();
        wait_valid("midscan");
        repeat (5) @(negedge clk);
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("midscan_rst");
        rst_in = 1'b0;
        @(negedge clk);
        check_zero("midscan_post");
        keypoint_ready = 1'b1;
        expect_kp(3, 1, 1);
        run_scan("rescan", 1, BASE + 1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
